alu_result_buffer: RTL and testbench
====================================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, >= 2).
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  ALU result on the inputs is valid this cycle.
REQ-005 SHALL have port a_in  input  8  operand A that produced the result.
REQ-006 SHALL have port b_in  input  8  operand B that produced the result.
REQ-007 SHALL have port op_in  input  3  opcode that produced the result.
REQ-008 SHALL have port result_in  input  16  ALU result_out.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-011 SHALL have ports out_a, out_b, out_op, out_result  output  8/8/3/16  head entry fields.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 SHALL have ports full, empty  output  1 each  count==DEPTH, count==0.
REQ-014 SHALL have port drop_cnt  output  8  dropped-entry counter (present only with macro, REQ-030).

Function
REQ-015 SHALL store {a_in, b_in, op_in, result_in} as one 35-bit entry in order of arrival.
REQ-016 SHALL push when in_valid=1 and (full=0 or a pop occurs in the same cycle).
REQ-017 SHALL pop when out_valid=1 and out_ready=1.
REQ-018 SHALL be first-word-fall-through: out_valid = !empty; out_* show head entry combinationally from storage.
REQ-019 SHALL make a push at edge N visible on out_* with out_valid=1 from cycle N+1 (1-cycle latency when empty).
REQ-020 SHALL drive out_a/out_b/out_op/out_result to 0 while empty=1.
REQ-021 SHALL keep count unchanged on simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-022 SHALL, when full and in_valid=1 and no pop, discard the incoming entry and leave storage, pointers, count unchanged.
REQ-023 SHALL, when empty and in_valid=1 and out_ready=1, push only (no pop of a non-existent entry).
REQ-024 SHALL wrap read and write pointers modulo DEPTH with no gap or duplicate entry.
REQ-025 SHALL hold out_* stable while out_valid=1 and out_ready=0.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, clear pointers and count: count=0, empty=1, full=0, out_valid=0, out_* = 0.
REQ-027 SHALL give reset priority over simultaneous push/pop; entries pending at reset are lost.
REQ-028 SHALL not require storage array contents to be reset.
REQ-029 SHALL clear drop_cnt to 0 on reset (when compiled in).

Configuration
REQ-030 SHALL compile drop counting in under macro ALU_RESBUF_DROP_CNT_EN: drop_cnt increments by 1 per discarded entry (REQ-022), saturating at 255.
REQ-031 SHALL, without ALU_RESBUF_DROP_CNT_EN, omit the drop_cnt port and its register; all other behaviour identical.

Structure
REQ-032 SHALL take entry typedef alu_entry_t (struct a, b, op, result) and width constants (ALU_OPND_W=8, ALU_OP_W=3, ALU_RES_W=16) from shared package alu_pkg.
REQ-033 SHALL place storage in sub-module alu_resbuf_mem (DEPTH x alu_entry_t, one write port, one async read port); pointer/count control stays in alu_result_buffer.

Verification
REQ-034 SHALL cover: reset, push a=8'h05 b=8'h03 op=3'd0 result=16'h0008 -> next cycle out_valid=1, out_result=16'h0008, count=1.
REQ-035 SHALL cover: 8 pushes with out_ready=0 (DEPTH=8) -> full=1, count=8; 9th push dropped, drop_cnt=1 (macro on); drained order matches push order.
REQ-036 SHALL cover: full, in_valid=1 and out_ready=1 same cycle -> head popped, new entry stored, count stays 8, drop_cnt unchanged.
REQ-037 SHALL cover: 20 continuous push+pop cycles (pointer wrap twice) -> every entry observed exactly once, in order, count constant.
REQ-038 SHALL cover: reset asserted with count=5 -> next cycle count=0, empty=1, out_valid=0, out_result=16'h0000.
REQ-039 SHALL cover: 300 drops with macro on -> drop_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU result entry type and field widths
package alu_pkg;
  localparam int ALU_OPND_W = 8;
  localparam int ALU_OP_W = 3;
  localparam int ALU_RES_W = 16;
  typedef struct packed {
    logic [ALU_OPND_W-1:0] a;
    logic [ALU_OPND_W-1:0] b;
    logic [ALU_OP_W-1:0] op;
    logic [ALU_RES_W-1:0] result;
  } alu_entry_t;
endpackage

// File: rtl/alu_resbuf_mem.sv
// alu_resbuf_mem: DEPTH x alu_entry_t storage, one write port, async read
module alu_resbuf_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  alu_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output alu_entry_t    rdata
);
  alu_entry_t mem [DEPTH];
  always_ff @(posedge clock) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: FWFT FIFO of ALU results; drop counter under ALU_RESBUF_DROP_CNT_EN
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [ALU_OPND_W-1:0] a_in,
  input  logic [ALU_OPND_W-1:0] b_in,
  input  logic [ALU_OP_W-1:0]   op_in,
  input  logic [ALU_RES_W-1:0]  result_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_OPND_W-1:0] out_a,
  output logic [ALU_OPND_W-1:0] out_b,
  output logic [ALU_OP_W-1:0]   out_op,
  output logic [ALU_RES_W-1:0]  out_result,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
`ifdef ALU_RESBUF_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  alu_entry_t wdata, rdata, head;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  // a pop frees a slot in the same cycle, so a full buffer can still accept
  assign push = in_valid && (!full || pop);
  assign wdata = '{a: a_in, b: b_in, op: op_in, result: result_in};
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + CW'(push) - CW'(pop);
    end
  end
`ifdef ALU_RESBUF_DROP_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) drop_cnt <= '0;
    else if (in_valid && full && !pop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif
  alu_resbuf_mem #(.DEPTH(DEPTH)) u_mem (
    .clock(clock),
    .we(push),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  always_comb begin
    head = empty ? '0 : rdata;
    out_a = head.a;
    out_b = head.b;
    out_op = head.op;
    out_result = head.result;
  end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed self-checking bench for alu_result_buffer (DEPTH=8)
module tb_alu_result_buffer;
  import alu_pkg::*;
  logic clock = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [7:0] a_in = 0, b_in = 0;
  logic [2:0] op_in = 0;
  logic [15:0] result_in = 0;
  logic out_valid, full, empty;
  logic [7:0] out_a, out_b;
  logic [2:0] out_op;
  logic [15:0] out_result;
  logic [3:0] count;
`ifdef ALU_RESBUF_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  int n_cmp = 0, n_err = 0;
  alu_entry_t q[$];

  alu_result_buffer #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .op_in(op_in), .result_in(result_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_result(out_result),
    .count(count), .full(full), .empty(empty)
`ifdef ALU_RESBUF_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic alu_entry_t mk(input int i);
    return '{a: 8'(i + 16), b: 8'(i + 32), op: 3'(i), result: 16'(i + 4096)};
  endfunction

  // drive one cycle and advance the reference queue the same way a FIFO of 8 should
  task automatic step(input logic v, input logic r, input alu_entry_t e);
    bit p, w;
    in_valid = v; out_ready = r;
    a_in = e.a; b_in = e.b; op_in = e.op; result_in = e.result;
    p = r && q.size() != 0;
    w = v && (q.size() < 8 || p);
    @(posedge clock); #1;
    if (p) void'(q.pop_front());
    if (w) q.push_back(e);
    in_valid = 0; out_ready = 0;
  endtask

  task automatic chk_head(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, "_res"}, 32'(out_result), 32'(q[0].result));
      chk({tag, "_abop"}, {13'd0, out_a, out_b, out_op}, {13'd0, q[0].a, q[0].b, q[0].op});
    end else chk({tag, "_res0"}, 32'(out_result), 0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_res", 32'(out_result), 0);
`ifdef ALU_RESBUF_DROP_CNT_EN
    chk("rst_drop", 32'(drop_cnt), 0);
`endif
    step(1, 1, '{a: 8'h05, b: 8'h03, op: 3'd0, result: 16'h0008});
    chk("p1_valid", 32'(out_valid), 1);
    chk("p1_res", 32'(out_result), 32'h0008);
    chk("p1_a", 32'(out_a), 32'h05);
    chk("p1_b", 32'(out_b), 32'h03);
    chk("p1_count", 32'(count), 1);
    step(0, 1, mk(0));
    chk("p1_drain_empty", 32'(empty), 1);
    chk("p1_drain_res", 32'(out_result), 0);

    for (int i = 0; i < 8; i++) step(1, 0, mk(i));
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 8);
    step(0, 0, mk(0));
    chk_head("hold");
    step(1, 0, '{a: 8'hEE, b: 8'hEE, op: 3'd7, result: 16'hDEAD});
    chk("drop_count", 32'(count), 8);
    chk_head("drop_head");
`ifdef ALU_RESBUF_DROP_CNT_EN
    chk("drop_cnt1", 32'(drop_cnt), 1);
`endif
    step(1, 1, mk(4104));
    chk("fullpp_count", 32'(count), 8);
    chk("fullpp_res", 32'(out_result), 32'h1001);
`ifdef ALU_RESBUF_DROP_CNT_EN
    chk("fullpp_drop", 32'(drop_cnt), 1);
`endif
    for (int i = 0; i < 8; i++) begin
      chk_head($sformatf("drain%0d", i));
      step(0, 1, mk(0));
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_res_seq_end", 32'(out_result), 0);

    step(1, 0, mk(8192));
    for (int i = 1; i <= 20; i++) begin
      chk_head($sformatf("wrap%0d", i));
      step(1, 1, mk(8192 + i));
      chk($sformatf("wrap_count%0d", i), 32'(count), 1);
    end
    chk("wrap_last_res", 32'(out_result), 32'(16'(8192 + 20 + 4096)));
    step(0, 1, mk(0));
    chk("wrap_empty", 32'(empty), 1);

    for (int i = 0; i < 5; i++) step(1, 0, mk(100 + i));
    chk("pre_rst_count", 32'(count), 5);
    reset = 1;
    step(1, 1, mk(200));
    reset = 0;
    q.delete();
    chk("rst5_count", 32'(count), 0);
    chk("rst5_empty", 32'(empty), 1);
    chk("rst5_valid", 32'(out_valid), 0);
    chk("rst5_res", 32'(out_result), 0);
`ifdef ALU_RESBUF_DROP_CNT_EN
    chk("rst5_drop", 32'(drop_cnt), 0);
    for (int i = 0; i < 8; i++) step(1, 0, mk(300 + i));
    for (int i = 0; i < 300; i++) step(1, 0, mk(999));
    chk("sat_drop", 32'(drop_cnt), 32'hFF);
    chk("sat_count", 32'(count), 8);
    chk_head("sat_head");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
